// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, size encodings and FSM states for the memory arbiter.
package mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
  localparam logic [1:0] IO_ADDR_TAG   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Illegal size 2'b11 falls through to a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      MEM_SIZE_BYTE: size_to_n = 3'd1;
      MEM_SIZE_HALF: size_to_n = 3'd2;
      default:       size_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - icache, load/store buffer and byte RAM signal bundle for the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                  if_en_in;
  logic [ARB_ADDR_W-1:0] if_addr_in;
  logic                  if_rdy_out;
  logic [ARB_DATA_W-1:0] if_data_out;

  logic                  ls_en_in;
  logic                  ls_wr_in;
  logic [1:0]            ls_size_in;
  logic [ARB_ADDR_W-1:0] ls_addr_in;
  logic [ARB_DATA_W-1:0] ls_wdata_in;
  logic                  ls_rdy_out;
  logic [ARB_DATA_W-1:0] ls_rdata_out;

  logic [7:0]            mem_din_in;
  logic [7:0]            mem_dout_out;
  logic [ARB_ADDR_W-1:0] mem_a_out;
  logic                  mem_wr_out;

  modport master (
    output if_en_in, if_addr_in, ls_en_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in, mem_din_in,
    input  if_rdy_out, if_data_out, ls_rdy_out, ls_rdata_out, mem_dout_out, mem_a_out, mem_wr_out
  );

  modport slave (
    input  if_en_in, if_addr_in, ls_en_in, ls_wr_in, ls_size_in, ls_addr_in, ls_wdata_in, mem_din_in,
    output if_rdy_out, if_data_out, ls_rdy_out, ls_rdata_out, mem_dout_out, mem_a_out, mem_wr_out
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - 2-way round-robin grant; the priority pointer flips to the side not just served.
module mem_arb_rr (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_req_if,
  input  logic i_req_ls,
  input  logic i_upd,
  output logic o_gnt_if,
  output logic o_gnt_ls
);

  logic r_prio_ls;

  always_comb begin
    o_gnt_if = i_req_if & (~i_req_ls | ~r_prio_ls);
    o_gnt_ls = i_req_ls & (~i_req_if | r_prio_ls);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_prio_ls <= 1'b0;
    end else if (i_upd && (o_gnt_if || o_gnt_ls)) begin
      r_prio_ls <= o_gnt_if;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/LSB arbiter serialising one request into 1/2/4 little-endian byte accesses.
// Define MEM_ARB_IO_STALL_EN to hold IO-space stores (addr[17:16]==2'b11) while io_full_in is high.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  input  logic         io_full_in,
  mem_arbiter_if.slave bus
);

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_owner_ls;
  logic                r_wr;
  logic [2:0]          r_n;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_mem_a;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_buf;
  logic [DATA_W-1:0]   r_if_data;
  logic [DATA_W-1:0]   r_ls_data;
  logic [7:0]          r_dout;
  logic                r_mem_wr;
  logic                r_if_rdy;
  logic                r_ls_rdy;

  logic                w_req_if;
  logic                w_req_ls;
  logic                w_gnt_if;
  logic                w_gnt_ls;
  logic                w_last;
  logic                w_abort;
  logic [2:0]          w_cnt_inc;
  logic [2:0]          w_cnt_dec;
  logic [ADDR_W-1:0]   w_new_addr;
  logic [ADDR_W-1:0]   w_step_addr;
  logic [DATA_W-1:0]   w_new_wdata;
  logic [DATA_W-1:0]   w_buf_nx;

  assign w_req_if = bus.if_en_in & ~flush_in;
`ifdef MEM_ARB_IO_STALL_EN
  assign w_req_ls = bus.ls_en_in
                  & ~(bus.ls_wr_in & (bus.ls_addr_in[17:16] == IO_ADDR_TAG) & io_full_in);
`else
  logic w_unused_io;
  assign w_unused_io = io_full_in;
  assign w_req_ls    = bus.ls_en_in;
`endif

  mem_arb_rr u_rr (
    .i_clk    (clk_in),
    .i_rstn   (rst_in),
    .i_req_if (w_req_if),
    .i_req_ls (w_req_ls),
    .i_upd    (rdy_in && (r_state == ST_IDLE)),
    .o_gnt_if (w_gnt_if),
    .o_gnt_ls (w_gnt_ls)
  );

  assign w_new_addr  = w_gnt_ls ? bus.ls_addr_in : bus.if_addr_in;
  assign w_new_wdata = w_gnt_ls ? bus.ls_wdata_in : '0;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_cnt_dec   = r_cnt - 3'd1;
  assign w_step_addr = r_addr + ADDR_W'(w_cnt_inc);
  // Reads run one extra step because each byte lands a cycle after its address.
  assign w_last      = r_wr ? (r_cnt == r_n - 3'd1) : (r_cnt == r_n);
  assign w_abort     = flush_in & ~r_owner_ls;

  always_comb begin
    w_buf_nx = r_buf;
    w_buf_nx[{w_cnt_dec[1:0], 3'b000} +: 8] = bus.mem_din_in;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_gnt_if || w_gnt_ls) w_state_nx = ST_RUN;
      ST_RUN:  if (w_abort)              w_state_nx = ST_IDLE;
               else if (w_last)          w_state_nx = ST_DONE;
      default:                           w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_owner_ls <= 1'b0;
      r_wr       <= 1'b0;
      r_n        <= 3'd0;
      r_cnt      <= 3'd0;
      r_addr     <= '0;
      r_mem_a    <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_if_data  <= '0;
      r_ls_data  <= '0;
      r_dout     <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_if_rdy   <= 1'b0;
      r_ls_rdy   <= 1'b0;
    end else if (rdy_in) begin
      r_if_rdy <= 1'b0;
      r_ls_rdy <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_if || w_gnt_ls) begin
            r_owner_ls <= w_gnt_ls;
            r_wr       <= w_gnt_ls & bus.ls_wr_in;
            r_n        <= w_gnt_ls ? size_to_n(bus.ls_size_in) : 3'd4;
            r_addr     <= w_new_addr;
            r_wdata    <= w_new_wdata;
            r_cnt      <= 3'd0;
            r_buf      <= '0;
            r_mem_a    <= w_new_addr;
            r_mem_wr   <= w_gnt_ls & bus.ls_wr_in;
            r_dout     <= w_new_wdata[7:0];
          end
        end
        ST_RUN: begin
          if (w_abort) begin
            r_mem_wr <= 1'b0;
          end else if (r_wr) begin
            if (w_last) begin
              r_mem_wr <= 1'b0;
              r_ls_rdy <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_inc;
              r_mem_a <= w_step_addr;
              r_dout  <= r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
            end
          end else begin
            if (r_cnt != 3'd0) r_buf <= w_buf_nx;
            if (w_last) begin
              if (r_owner_ls) begin
                r_ls_data <= w_buf_nx;
                r_ls_rdy  <= 1'b1;
              end else begin
                r_if_data <= w_buf_nx;
                r_if_rdy  <= 1'b1;
              end
            end else begin
              r_cnt   <= w_cnt_inc;
              r_mem_a <= w_step_addr;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_rdy_out   = r_if_rdy;
  assign bus.if_data_out  = r_if_data;
  assign bus.ls_rdy_out   = r_ls_rdy;
  assign bus.ls_rdata_out = r_ls_data;
  assign bus.mem_a_out    = r_mem_a;
  assign bus.mem_dout_out = r_dout;
  assign bus.mem_wr_out   = r_mem_wr & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a byte-array reference.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_in, rdy_in, flush_in, io_full_in;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .io_full_in (io_full_in),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram    [0:8191];
  logic [7:0]  shadow [0:8191];
  logic [39:0] wlog   [$];
  logic        poke_en;
  logic [12:0] poke_a;
  logic [7:0]  poke_d;

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_a] <= poke_d;
    end else if (bus.mem_wr_out) begin
      ram[bus.mem_a_out[12:0]] <= bus.mem_dout_out;
      wlog.push_back({bus.mem_a_out, bus.mem_dout_out});
    end
    bus.mem_din_in <= ram[bus.mem_a_out[12:0]];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a  = a[12:0];
    poke_d  = d;
    shadow[a[12:0]] = d;
    step();
    poke_en = 1'b0;
  endtask

  task automatic wait_rdy(input bit is_ls, input int start, output int lat);
    lat = start;
    do begin
      step();
      lat++;
    end while (!(is_ls ? bus.ls_rdy_out : bus.if_rdy_out) && lat < 40);
  endtask

  task automatic run_req(input bit is_ls, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] data);
    if (is_ls) begin
      bus.ls_en_in = 1'b1; bus.ls_wr_in = wr; bus.ls_size_in = size;
      bus.ls_addr_in = addr; bus.ls_wdata_in = wdata;
    end else begin
      bus.if_en_in = 1'b1; bus.if_addr_in = addr;
    end
    wait_rdy(is_ls, 0, lat);
    data = is_ls ? bus.ls_rdata_out : bus.if_data_out;
    bus.if_en_in = 1'b0;
    bus.ls_en_in = 1'b0;
    step();
  endtask

  task automatic chk_wlog(input string tag, input int base, input logic [31:0] addr,
                          input logic [31:0] wd, input int n);
    chk({tag, "_beats"}, 40'(wlog.size() - base), 40'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < wlog.size())
        chk({tag, "_byte"}, wlog[base + i], {addr + 32'(i), wd[8*i +: 8]});
    end
  endtask

  function automatic int n_of(input bit is_ls, input logic [1:0] size);
    if (!is_ls) return 4;
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  int          lat, base, n;
  logic [31:0] data, exp_d, last_ls, wd, addr;
  bit          is_ls, wr, seen;
  logic [1:0]  size;
  int          order [$];

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_full_in = 1'b0; poke_en = 1'b0;
    poke_a = '0; poke_d = '0;
    bus.if_en_in = 1'b0; bus.if_addr_in = '0; bus.ls_en_in = 1'b0; bus.ls_wr_in = 1'b0;
    bus.ls_size_in = '0; bus.ls_addr_in = '0; bus.ls_wdata_in = '0;
    repeat (3) step();
    chk("rst_if_rdy",  40'(bus.if_rdy_out),   40'd0);
    chk("rst_ls_rdy",  40'(bus.ls_rdy_out),   40'd0);
    chk("rst_mem_wr",  40'(bus.mem_wr_out),   40'd0);
    chk("rst_mem_a",   40'(bus.mem_a_out),    40'd0);
    chk("rst_dout",    40'(bus.mem_dout_out), 40'd0);
    chk("rst_if_data", 40'(bus.if_data_out),  40'd0);
    chk("rst_ls_data", 40'(bus.ls_rdata_out), 40'd0);
    rst_in = 1'b1;
    step();

    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    run_req(1'b0, 1'b0, 2'b00, 32'h1000, 32'h0, lat, data);
    chk("if_read_lat",  40'(lat),  40'd6);
    chk("if_read_data", 40'(data), 40'h513);

    base = wlog.size();
    run_req(1'b1, 1'b1, 2'b10, 32'h20, 32'hDEADBEEF, lat, data);
    chk("st_word_lat", 40'(lat), 40'd5);
    chk_wlog("st_word", base, 32'h20, 32'hDEADBEEF, 4);

    poke(32'h31, 8'h80); poke(32'h32, 8'hFF);
    run_req(1'b1, 1'b0, 2'b01, 32'h31, 32'h0, lat, data);
    chk("ld_half_lat",  40'(lat),  40'd4);
    chk("ld_half_data", 40'(data), 40'h0000FF80);

    for (int i = 32'h200; i < 32'h280; i++) poke(32'(i), 8'($urandom));

    rst_in = 1'b0;
    repeat (2) step();
    rst_in = 1'b1;
    bus.if_en_in = 1'b1; bus.if_addr_in = 32'h210;
    bus.ls_en_in = 1'b1; bus.ls_wr_in = 1'b0; bus.ls_size_in = 2'b00; bus.ls_addr_in = 32'h204;
    for (int c = 0; c < 80 && order.size() < 3; c++) begin
      step();
      if (bus.if_rdy_out) order.push_back(0);
      if (bus.ls_rdy_out) order.push_back(1);
    end
    bus.if_en_in = 1'b0; bus.ls_en_in = 1'b0;
    step();
    chk("rr_grant0", 40'((order.size() > 0) ? order[0] : 9), 40'd0);
    chk("rr_grant1", 40'((order.size() > 1) ? order[1] : 9), 40'd1);
    chk("rr_grant2", 40'((order.size() > 2) ? order[2] : 9), 40'd0);
    last_ls = {24'd0, shadow[13'h204]};
    chk("rr_ls_data", 40'(bus.ls_rdata_out), 40'(last_ls));

    base = wlog.size(); seen = 1'b0;
    bus.if_en_in = 1'b1; bus.if_addr_in = 32'h100;
    step();
    bus.ls_en_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b10;
    bus.ls_addr_in = 32'h60; bus.ls_wdata_in = 32'hCAFEF00D;
    repeat (2) step();
    flush_in = 1'b1;
    step();
    if (bus.if_rdy_out) seen = 1'b1;
    flush_in = 1'b0; bus.if_en_in = 1'b0;
    lat = 0;
    do begin
      step(); lat++;
      if (bus.if_rdy_out) seen = 1'b1;
    end while (!bus.ls_rdy_out && lat < 40);
    bus.ls_en_in = 1'b0;
    step();
    chk("flush_ls_lat", 40'(lat),  40'd5);
    chk("flush_no_if",  40'(seen), 40'd0);
    chk_wlog("flush_st", base, 32'h60, 32'hCAFEF00D, 4);

    seen = 1'b0;
    flush_in = 1'b1; bus.if_en_in = 1'b1; bus.if_addr_in = 32'h210;
    repeat (8) begin
      step();
      if (bus.if_rdy_out) seen = 1'b1;
    end
    flush_in = 1'b0; bus.if_en_in = 1'b0;
    chk("flush_mask", 40'(seen), 40'd0);
    run_req(1'b0, 1'b0, 2'b00, 32'h210, 32'h0, lat, data);
    chk("post_flush_lat", 40'(lat), 40'd6);
    chk("post_flush_data", 40'(data),
        40'({shadow[13'h213], shadow[13'h212], shadow[13'h211], shadow[13'h210]}));

    base = wlog.size();
    bus.ls_en_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b10;
    bus.ls_addr_in = 32'h40; bus.ls_wdata_in = 32'h11223344;
    repeat (2) step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pause_wr", 40'(bus.mem_wr_out), 40'd0);
      step();
    end
    rdy_in = 1'b1;
    wait_rdy(1'b1, 5, lat);
    bus.ls_en_in = 1'b0;
    step();
    chk("pause_lat", 40'(lat), 40'd8);
    chk_wlog("pause_st", base, 32'h40, 32'h11223344, 4);

    base = wlog.size();
    io_full_in = 1'b1;
`ifdef MEM_ARB_IO_STALL_EN
    seen = 1'b0;
    bus.ls_en_in = 1'b1; bus.ls_wr_in = 1'b1; bus.ls_size_in = 2'b00;
    bus.ls_addr_in = 32'h30010; bus.ls_wdata_in = 32'h5A;
    repeat (6) begin
      step();
      if (bus.ls_rdy_out || bus.mem_wr_out) seen = 1'b1;
    end
    chk("io_stall", 40'(seen), 40'd0);
    io_full_in = 1'b0;
    wait_rdy(1'b1, 0, lat);
    bus.ls_en_in = 1'b0;
    step();
`else
    run_req(1'b1, 1'b1, 2'b00, 32'h30010, 32'h5A, lat, data);
`endif
    io_full_in = 1'b0;
    chk("io_st_lat", 40'(lat), 40'd2);
    chk_wlog("io_st", base, 32'h30010, 32'h5A, 1);

    for (int it = 0; it < 24; it++) begin
      is_ls = ($urandom_range(0, 2) != 0);
      wr    = is_ls & $urandom_range(0, 1);
      size  = 2'($urandom_range(0, 3));
      addr  = 32'h200 + 32'($urandom_range(0, 32'h7B));
      wd    = $urandom;
      n     = n_of(is_ls, size);
      exp_d = '0;
      for (int i = 0; i < n; i++) exp_d[8*i +: 8] = shadow[13'(addr + 32'(i))];
      run_req(is_ls, wr, size, addr, wd, lat, data);
      chk("rnd_lat", 40'(lat), 40'(n + (wr ? 1 : 2)));
      if (wr) begin
        for (int i = 0; i < n; i++) shadow[13'(addr + 32'(i))] = wd[8*i +: 8];
        chk("rnd_ls_hold", 40'(data), 40'(last_ls));
      end else begin
        chk(is_ls ? "rnd_ld_data" : "rnd_if_data", 40'(data), 40'(exp_d));
        if (is_ls) last_ls = exp_d;
      end
    end
    for (int i = 32'h200; i < 32'h280; i++)
      chk("rnd_ram", 40'(ram[13'(i)]), 40'(shadow[13'(i)]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
